branch_predictor: RTL and testbench

- Gshare direction predictor for the 5-stage MIPS pipeline.
- Predicts conditional branches in Decode and carries each prediction into Execute alongside the branch.
- Resolves the branch in Execute, updates its pattern history table (PHT) and global history register (GHR), and raises predict_wrong plus a redirect PC.
- predict_wrong feeds the hazard unit, which turns it into flushD/flushE.

---
 rtl/branch_predictor_if.sv | 26 ++
 rtl/branch_predictor.sv | 79 +++++++
 tb/tb_branch_predictor.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Pipeline-side signals of the gshare predictor: Decode lookup, Execute
// resolution, redirect and statistics counters.
interface branch_predictor_if;
  logic [31:0] pcD;
  logic        branchD;
  logic        stallD;
  logic        flushE;
  logic        actual_takeE;
  logic [31:0] pc_plus4E;
  logic [31:0] branch_targetE;
  logic        pred_takeD;
  logic        predict_wrong;
  logic [31:0] pc_redirectE;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  modport master (
    output pcD, branchD, stallD, flushE, actual_takeE, pc_plus4E, branch_targetE,
    input  pred_takeD, predict_wrong, pc_redirectE, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  pcD, branchD, stallD, flushE, actual_takeE, pc_plus4E, branch_targetE,
    output pred_takeD, predict_wrong, pc_redirectE, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Gshare direction predictor: predicts in Decode, resolves in Execute,
// updates PHT/GHR on the resolving edge and raises the redirect.
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int GHR_W = 6
) (
    input logic clk,
    input logic rst,
    branch_predictor_if.slave bp
);
    localparam int unsigned N_ENT = 1 << IDX_W;

    logic [1:0]       pht [N_ENT];
    logic [GHR_W-1:0] ghr;
    logic [IDX_W-1:0] ghr_ext;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] idx_e;
    logic             valid_e;
    logic             pred_take_e;
    logic             mispredict;
    logic [31:0]      branch_cnt_q;
    logic [31:0]      mispredict_cnt_q;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{bp.pcD[31:IDX_W+2], bp.pcD[1:0]};

    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_W-1:0] = ghr;
    end

    assign idx_d         = bp.pcD[IDX_W+1:2] ^ ghr_ext;
    assign bp.pred_takeD = bp.branchD & pht[idx_d][1];

    assign mispredict       = valid_e & (pred_take_e != bp.actual_takeE);
    assign bp.predict_wrong = mispredict;
    assign bp.pc_redirectE  = mispredict ? (bp.actual_takeE ? bp.branch_targetE : bp.pc_plus4E)
                                         : '0;
    assign bp.branch_cnt     = branch_cnt_q;
    assign bp.mispredict_cnt = mispredict_cnt_q;

    // Lookup reads the pre-edge table, so a same-index update shows up next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_ENT; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (valid_e) begin
            if (bp.actual_takeE) begin
                if (pht[idx_e] != 2'b11) pht[idx_e] <= pht[idx_e] + 2'd1;
            end else begin
                if (pht[idx_e] != 2'b00) pht[idx_e] <= pht[idx_e] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr              <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (valid_e) begin
            ghr              <= {ghr[GHR_W-2:0], bp.actual_takeE};
            branch_cnt_q     <= branch_cnt_q + 32'd1;
            mispredict_cnt_q <= mispredict_cnt_q + {31'd0, mispredict};
        end
    end

    // A stalled Decode branch must not enter Execute twice.
    always_ff @(posedge clk) begin
        if (rst || bp.flushE || bp.stallD) begin
            valid_e <= 1'b0;
        end else begin
            valid_e     <= bp.branchD;
            pred_take_e <= bp.pred_takeD;
            idx_e       <= idx_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor against an
// integer-level gshare reference model.
module tb_branch_predictor;
    localparam int NENT = 64;

    logic clk;
    logic rst;

    branch_predictor_if bpif ();

    branch_predictor #(.IDX_W(6), .GHR_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bpif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_vec;
    int unsigned n_err;

    // Reference state
    int          m_pht [NENT];
    int          m_ghr;
    bit          m_valid;
    bit          m_pred;
    int          m_idx;
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    // Outputs sampled just before the most recent step's edge
    logic        s_pred;
    logic        s_wrong;
    logic [31:0] s_redir;
    logic [31:0] s_bcnt;
    logic [31:0] s_mcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) m_pht[i] = 1;
        m_ghr   = 0;
        m_valid = 1'b0;
        m_bcnt  = 32'd0;
        m_mcnt  = 32'd0;
    endtask

    function automatic logic [31:0] pc_for(input int idx);
        return 32'h0040_0000 | (32'((idx ^ m_ghr) % NENT) << 2);
    endfunction

    // One cycle: drive, check against the model, clock, advance the model.
    task automatic step(input logic r, input logic [31:0] pc, input logic br,
                        input logic st, input logic fl, input logic at,
                        input logic [31:0] tgt, input logic [31:0] p4);
        int          idx;
        bit          e_pred;
        bit          e_wrong;
        logic [31:0] e_redir;
        rst                 = r;
        bpif.pcD            = pc;
        bpif.branchD        = br;
        bpif.stallD         = st;
        bpif.flushE         = fl;
        bpif.actual_takeE   = at;
        bpif.branch_targetE = tgt;
        bpif.pc_plus4E      = p4;
        #1;
        idx     = int'((pc >> 2) % 32'(NENT)) ^ m_ghr;
        e_pred  = br && (m_pht[idx] >= 2);
        e_wrong = m_valid && (m_pred != at);
        e_redir = e_wrong ? (at ? tgt : p4) : 32'd0;
        s_pred  = bpif.pred_takeD;
        s_wrong = bpif.predict_wrong;
        s_redir = bpif.pc_redirectE;
        s_bcnt  = bpif.branch_cnt;
        s_mcnt  = bpif.mispredict_cnt;
        check("pred_takeD",     {31'd0, s_pred},  {31'd0, e_pred});
        check("predict_wrong",  {31'd0, s_wrong}, {31'd0, e_wrong});
        check("pc_redirectE",   s_redir, e_redir);
        check("branch_cnt",     s_bcnt,  m_bcnt);
        check("mispredict_cnt", s_mcnt,  m_mcnt);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (m_valid) begin
                m_pht[m_idx] = at ? ((m_pht[m_idx] == 3) ? 3 : m_pht[m_idx] + 1)
                                  : ((m_pht[m_idx] == 0) ? 0 : m_pht[m_idx] - 1);
                m_ghr  = (m_ghr * 2 + int'(at)) % NENT;
                m_bcnt = m_bcnt + 32'd1;
                if (e_wrong) m_mcnt = m_mcnt + 32'd1;
            end
            m_valid = !st && !fl && br;
            m_pred  = e_pred;
            m_idx   = idx;
        end
        #1;
    endtask

    task automatic idle(input logic at);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, at, 32'hDEAD_0000, 32'hBEEF_0004);
    endtask

    logic [31:0] pc;
    logic [31:0] cnt_before;

    initial begin
        n_vec = 0;
        n_err = 0;
        bpif.pcD = '0; bpif.branchD = 1'b0; bpif.stallD = 1'b0; bpif.flushE = 1'b0;
        bpif.actual_takeE = 1'b0; bpif.pc_plus4E = '0; bpif.branch_targetE = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // Cold mispredict
        step(1'b0, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("cold_reset_bcnt", s_bcnt, 32'd0);
        check("cold_pred", {31'd0, s_pred}, 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0040, 32'h0040_0014);
        check("cold_wrong", {31'd0, s_wrong}, 32'd1);
        check("cold_redir", s_redir, 32'h0040_0040);
        step(1'b0, 32'h0040_0014, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("cold_bcnt", s_bcnt, 32'd1);
        check("cold_mcnt", s_mcnt, 32'd1);
        check("cold_pht4_taken", {31'd0, s_pred}, 32'd1);

        // Saturation up then down at index 5
        for (int k = 0; k < 4; k++) begin
            step(1'b0, pc_for(5), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            idle(1'b1);
            check("sat_up_wrong", {31'd0, s_wrong}, (k == 0) ? 32'd1 : 32'd0);
        end
        step(1'b0, pc_for(5), 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("sat_up_pred", {31'd0, s_pred}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, pc_for(5), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            idle(1'b0);
        end
        step(1'b0, pc_for(5), 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("sat_dn_pred", {31'd0, s_pred}, 32'd0);

        // Stall: branch enters Execute once
        cnt_before = m_bcnt;
        pc = pc_for(7);
        step(1'b0, pc, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, pc, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        check("stall_no_wrong", {31'd0, s_wrong}, 32'd0);
        step(1'b0, pc, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        idle(1'b0);
        idle(1'b1);
        check("stall_bcnt", s_bcnt, cnt_before + 32'd1);

        // Flush: no resolution, no state change
        cnt_before = m_bcnt;
        step(1'b0, pc_for(3), 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        idle(1'b1);
        check("flush_wrong", {31'd0, s_wrong}, 32'd0);
        idle(1'b0);
        check("flush_bcnt", s_bcnt, cnt_before);

        // Same-index collision at index 9 from a fresh table
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, pc_for(9), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, pc_for(9), 1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 32'h0);
        check("coll_old", {31'd0, s_pred}, 32'd0);
        step(1'b0, pc_for(9), 1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0100, 32'h0);
        check("coll_new", {31'd0, s_pred}, 32'd1);

        // Reset mid-operation with a mismatching branch in Execute
        step(1'b0, pc_for(12), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, pc_for(12), 1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0200, 32'h0);
        check("rst_pending_wrong", {31'd0, s_wrong}, 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0200, 32'h0);
        check("rst_wrong", {31'd0, s_wrong}, 32'd0);
        check("rst_redir", s_redir, 32'd0);
        check("rst_bcnt",  s_bcnt,  32'd0);
        check("rst_mcnt",  s_mcnt,  32'd0);
        for (int i = 0; i < NENT; i++) begin
            step(1'b0, 32'h0040_0000 | (32'(i) << 2), 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            check("rst_pht", {31'd0, s_pred}, 32'd0);
        end

        // Random traffic on a small PC pool to force index reuse
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0),
                 32'h0040_0000 + ($urandom_range(0, 127) << 2),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0),
                 1'($urandom),
                 $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
